// File: rtl/serial_logic_unit.sv
// Digit-serial 32-bit AND/OR/XOR/NOR unit; done/out arrive N+1 edges after start (N = 32/DIGIT_W).
// No backpressure: start is taken only in IDLE and ignored while busy or done, never queued.
module serial_logic_unit #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);
    localparam int N     = 32 / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [1:0]         op_q;
    logic [31:0]        acc;
    logic [31:0]        acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] dig;
    logic               last;

    always_comb begin
        dig       = '0;
        acc_nxt   = acc;
        last      = 1'b0;
        state_nxt = state;
        case (op_q)
            2'b00:   dig = a_q[DIGIT_W-1:0] & b_q[DIGIT_W-1:0];
            2'b01:   dig = a_q[DIGIT_W-1:0] | b_q[DIGIT_W-1:0];
            2'b10:   dig = a_q[DIGIT_W-1:0] ^ b_q[DIGIT_W-1:0];
            default: dig = ~(a_q[DIGIT_W-1:0] | b_q[DIGIT_W-1:0]);
        endcase
        // Result digits enter at the MSB so the first (lowest) digit ends up at bit 0.
        acc_nxt = {dig, acc[31:DIGIT_W]};
        last    = (cnt == CNT_W'(N - 1));
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            acc   <= '0;
            cnt   <= '0;
            out   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= in1;
                        b_q  <= in2;
                        op_q <= op;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_q <= a_q >> DIGIT_W;
                    b_q <= b_q >> DIGIT_W;
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    // out is written only here, so it changes once per operation.
                    if (last) out <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
